// File: rtl/stream_rr_arb.sv
// stream_rr_arb: packet-aware round-robin arbiter that merges N_IN
// AXI-Stream requesters onto one registered output stream.
// A grant is taken in IDLE and held in LOCK until the granted requester's
// tlast beat has been accepted, so packets never interleave.
// Optional build macro: STREAM_ARB_PRIO0_EN gives requester 0 absolute
// priority in IDLE; rr_ptr then only advances on non-zero grants.
//
// Handshake: a beat moves across an interface on a rising edge where
// tvalid and tready are both high. A source holds tvalid and its payload
// stable until that happens; tready may be any function of the sink's state.
module stream_rr_arb #(
  parameter int N_IN = 4,
  parameter int n    = 5,
  parameter int nb   = n * 8,
  parameter int IW   = $clog2(N_IN)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_IN*nb-1:0]   in_tdata,
  input  logic [N_IN-1:0]      in_tvalid,
  input  logic [N_IN-1:0]      in_tlast,
  output logic [N_IN-1:0]      in_tready,
  output logic [nb-1:0]        out_tdata,
  output logic                 out_tvalid,
  output logic                 out_tlast,
  output logic [IW-1:0]        out_tid,
  input  logic                 out_tready,
  output logic                 busy,
  output logic                 state_dbg,
  output logic [IW-1:0]        rr_ptr_dbg
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic [IW:0]     cand;
  logic            found;
  logic            any_valid;
  logic            can_load;
  logic            accept;
  logic            gnt_valid;
  logic            gnt_last;
  logic [nb-1:0]   gnt_data;

  assign any_valid  = |in_tvalid;
  assign can_load   = ~out_tvalid | out_tready;
  assign next_ptr   = (grant_q == IW'(N_IN - 1)) ? '0 : grant_q + IW'(1);
  assign state_dbg  = (state_q == LOCK);
  assign rr_ptr_dbg = rr_ptr_q;

  // Search for the first valid requester starting at rr_ptr, wrapping at N_IN-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_IN)) cand = cand - (IW+1)'(N_IN);
      if (!found && in_tvalid[cand[IW-1:0]]) begin
        pick  = cand[IW-1:0];
        found = 1'b1;
      end
    end
`ifdef STREAM_ARB_PRIO0_EN
    if (in_tvalid[0]) pick = '0;
`endif
  end

  // Select the granted requester's valid, last and data.
  always_comb begin
    gnt_valid = in_tvalid[grant_q];
    gnt_last  = in_tlast[grant_q];
    gnt_data  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_q == i[IW-1:0]) gnt_data = in_tdata[i*nb +: nb];
    end
  end

  // FSM state register together with grant and round-robin pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, release after the tlast beat in LOCK.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept && gnt_last) begin
          state_d = IDLE;
`ifdef STREAM_ARB_PRIO0_EN
          if (grant_q != '0) rr_ptr_d = next_ptr;
`else
          rr_ptr_d = next_ptr;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted requester sees ready, and only in LOCK.
  always_comb begin
    in_tready = '0;
    accept    = 1'b0;
    busy      = (state_q == LOCK);
    if (state_q == LOCK) begin
      in_tready[grant_q] = can_load;
      accept             = gnt_valid & can_load;
    end
  end

  // Output register: load on accept, drop valid once the beat is taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
      out_tid    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tlast  <= gnt_last;
      out_tdata  <= gnt_data;
      out_tid    <= grant_q;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arb.sv
// tb_stream_rr_arb: directed bench for stream_rr_arb with a packet/FIFO
// level reference model checked every cycle, plus literal expectations.
module tb_stream_rr_arb;
  localparam int N  = 4;
  localparam int NB = 40;
  localparam int IW = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [N*NB-1:0]   in_tdata = '0;
  logic [N-1:0]      in_tvalid = '0;
  logic [N-1:0]      in_tlast = '0;
  logic [N-1:0]      in_tready;
  logic [NB-1:0]     out_tdata;
  logic              out_tvalid;
  logic              out_tlast;
  logic [IW-1:0]     out_tid;
  logic              out_tready = 1'b1;
  logic              busy;
  logic              state_dbg;
  logic [IW-1:0]     rr_ptr_dbg;

  stream_rr_arb #(.N_IN(N), .n(5)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tid(out_tid), .out_tready(out_tready),
    .busy(busy), .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  drv_abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // Arbiter is a lock flag + owner + pointer; the output register is a
  // one-deep FIFO of beats {tid, last, data} held in exp_q.
  bit                 m_locked = 1'b0;
  int                 m_owner = 0;
  int                 m_ptr = 0;
  logic [IW+NB:0]     exp_q[$];
  logic [N-1:0]       exp_rdy;
  logic [IW+NB:0]     head;
  bit                 m_acc;

  // Delivered-beat log for literal checks.
  int                 log_tid[$];
  int                 log_cyc[$];
  int                 log_ptr[$];
  logic [NB-1:0]      log_data[$];
  bit                 log_last[$];

  function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
    int c;
`ifdef STREAM_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  // Compare DUT against model every cycle, then advance model over the next edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_out_tvalid", out_tvalid, 0);
      chk("rst_in_tready", in_tready, 0);
      chk("rst_busy", busy, 0);
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      if (m_locked && (exp_q.size() == 0 || out_tready)) exp_rdy[m_owner] = 1'b1;
      chk("out_tvalid", out_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("out_tdata", out_tdata, head[NB-1:0]);
        chk("out_tlast", out_tlast, head[NB]);
        chk("out_tid", out_tid, head[IW+NB:NB+1]);
      end
      chk("in_tready", in_tready, exp_rdy);
      chk("busy", busy, m_locked);
      if (out_tvalid && out_tready) begin
        log_tid.push_back(int'(out_tid));
        log_cyc.push_back(cyc);
        log_ptr.push_back(int'(rr_ptr_dbg));
        log_data.push_back(out_tdata);
        log_last.push_back(out_tlast);
      end
      m_acc = m_locked && in_tvalid[m_owner] && exp_rdy[m_owner];
      if (exp_q.size() != 0 && out_tready) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({IW'(m_owner), in_tlast[m_owner], in_tdata[m_owner*NB +: NB]});
      if (!m_locked) begin
        if (|in_tvalid) begin
          m_owner  = pick_winner(in_tvalid, m_ptr);
          m_locked = 1'b1;
        end
      end else if (m_acc && in_tlast[m_owner]) begin
        m_locked = 1'b0;
`ifdef STREAM_ARB_PRIO0_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pkt(input int idx, input int nbeats, input logic [NB-1:0] base,
                          input int stall_after, input int stall_len);
    int t;
    for (int b = 0; b < nbeats; b++) begin
      if (drv_abort) return;
      if (b == stall_after && stall_len > 0) begin
        in_tvalid[idx] = 1'b0;
        repeat (stall_len) @(posedge aclk);
        #1;
      end
      in_tvalid[idx] = 1'b1;
      in_tlast[idx]  = (b == nbeats - 1);
      in_tdata[idx*NB +: NB] = base + NB'(b << 8);
      t = 0;
      forever begin
        @(negedge aclk);
        if (drv_abort) return;
        if (in_tready[idx]) break;
        t++;
        if (t > 60) begin
          fail_now("drv_wait_ready");
          in_tvalid[idx] = 1'b0;
          return;
        end
      end
      @(posedge aclk);
      #1;
    end
    in_tvalid[idx] = 1'b0;
    in_tlast[idx]  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    repeat (2) @(posedge aclk);
    while ((busy || out_tvalid) && t < 100) begin
      @(posedge aclk);
      t++;
    end
    if (t >= 100) fail_now("drain");
    #1;
  endtask

  task automatic clr_log();
    log_tid.delete(); log_cyc.delete(); log_ptr.delete();
    log_data.delete(); log_last.delete();
  endtask

  task automatic chk_log(input int k, input int tid, input logic [NB-1:0] data, input bit last);
    if (k >= log_tid.size()) begin
      fail_now("log_missing_beat");
    end else begin
      chk("log_tid", log_tid[k], tid);
      chk("log_data", log_data[k], data);
      chk("log_last", log_last[k], last);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int c0;
  int acc_cnt;
  int t;

  initial begin
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Reset values
    @(negedge aclk);
    chk("reset_out_tvalid", out_tvalid, 0);
    chk("reset_out_tdata", out_tdata, 0);
    chk("reset_out_tlast", out_tlast, 0);
    chk("reset_out_tid", out_tid, 0);
    chk("reset_in_tready", in_tready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", state_dbg, 0);
    chk("reset_rr_ptr", rr_ptr_dbg, 0);

    // Simultaneous requests: four 3-beat packets, order 0,1,2,3
    @(posedge aclk); #1;
    clr_log();
    c0 = cyc;
    fork
      send_pkt(0, 3, 40'hA0, -1, 0);
      send_pkt(1, 3, 40'hA1, -1, 0);
      send_pkt(2, 3, 40'hA2, -1, 0);
      send_pkt(3, 3, 40'hA3, -1, 0);
    join
    wait_drain();
    chk("simul_beats", log_tid.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk_log(k, k / 3, 40'hA0 + NB'(k / 3) + NB'((k % 3) << 8), (k % 3) == 2);
      if (k < log_cyc.size()) chk("simul_timing", log_cyc[k] - c0, 2 + k + k / 3);
    end
    chk("simul_rr_ptr", rr_ptr_dbg, 0);

    // Backpressure on requester 2
    @(posedge aclk); #1;
    clr_log();
    out_tready = 1'b0;
    fork
      send_pkt(2, 3, 40'h20, -1, 0);
      begin
        repeat (2) @(posedge aclk);
        for (int i = 0; i < 5; i++) begin
          @(negedge aclk);
          chk("bp_out_tvalid", out_tvalid, 1);
          chk("bp_out_tdata", out_tdata, 40'h20);
          chk("bp_in_tready", in_tready, 0);
        end
        @(posedge aclk); #1;
        out_tready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_beats", log_tid.size(), 3);
    chk_log(0, 2, 40'h20, 0);
    chk_log(1, 2, 40'h120, 0);
    chk_log(2, 2, 40'h220, 1);
    chk("bp_rr_ptr", rr_ptr_dbg, 3);

    // Single-beat packets from 3 and 1 with rr_ptr=3
    @(posedge aclk); #1;
    clr_log();
    fork
      send_pkt(3, 1, 40'h33, -1, 0);
      send_pkt(1, 1, 40'h11, -1, 0);
    join
    wait_drain();
    chk("sb_beats", log_tid.size(), 2);
    chk_log(0, 3, 40'h33, 1);
    chk_log(1, 1, 40'h11, 1);
    if (log_ptr.size() >= 2) begin
      chk("sb_ptr_wrap", log_ptr[0], 0);
      chk("sb_ptr_after", log_ptr[1], 2);
    end else fail_now("sb_ptr_log");

    // Mid-packet stall of requester 1 while requester 0 waits
    @(posedge aclk); #1;
    clr_log();
    fork
      send_pkt(1, 4, 40'h100, 2, 3);
      begin
        repeat (2) @(posedge aclk);
        #1;
        send_pkt(0, 2, 40'h200, -1, 0);
      end
    join
    wait_drain();
    chk("stall_beats", log_tid.size(), 6);
    for (int k = 0; k < 4; k++) chk_log(k, 1, 40'h100 + NB'(k << 8), k == 3);
    chk_log(4, 0, 40'h200, 0);
    chk_log(5, 0, 40'h300, 1);
`ifdef STREAM_ARB_PRIO0_EN
    chk("stall_rr_ptr", rr_ptr_dbg, 2);
`else
    chk("stall_rr_ptr", rr_ptr_dbg, 1);
`endif

    // Requesters 0 and 2 together
    @(posedge aclk); #1;
    clr_log();
    fork
      send_pkt(0, 1, 40'h0E, -1, 0);
      send_pkt(2, 1, 40'h2E, -1, 0);
    join
    wait_drain();
`ifdef STREAM_ARB_PRIO0_EN
    chk_log(0, 0, 40'h0E, 1);
    chk_log(1, 2, 40'h2E, 1);
`else
    chk_log(0, 2, 40'h2E, 1);
    chk_log(1, 0, 40'h0E, 1);
`endif

    // Reset mid-packet: two beats of a 4-beat packet, then reset
    @(posedge aclk); #1;
    clr_log();
    fork
      send_pkt(3, 4, 40'h300, -1, 0);
      begin
        acc_cnt = 0;
        t = 0;
        while (acc_cnt < 2 && t < 50) begin
          @(negedge aclk);
          if (in_tvalid[3] && in_tready[3]) acc_cnt++;
          t++;
        end
        if (acc_cnt < 2) fail_now("rst_mid_wait");
        @(posedge aclk); #1;
        drv_abort = 1'b1;
        aresetn   = 1'b0;
        #1;
        chk("rstmid_out_tvalid", out_tvalid, 0);
        chk("rstmid_in_tready", in_tready, 0);
        chk("rstmid_busy", busy, 0);
      end
    join
    in_tvalid = '0;
    in_tlast  = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    drv_abort = 1'b0;
    @(negedge aclk);
    chk("rstmid_state", state_dbg, 0);
    chk("rstmid_rr_ptr", rr_ptr_dbg, 0);
    chk("rstmid_out_idle", out_tvalid, 0);
    clr_log();
    @(posedge aclk); #1;
    send_pkt(2, 1, 40'h2F, -1, 0);
    wait_drain();
    chk("recover_beats", log_tid.size(), 1);
    chk_log(0, 2, 40'h2F, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
